// File: rtl/decode_collate_ctrl.sv
// Collates 32/64-bit instruction words ahead of decode and issues them downstream.
// Optional: DECODE_COLLATE_WFID_CHECK_EN enables wavefront-match checking of second words.
module decode_collate_ctrl #(
    parameter int unsigned WFID_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [31:0]           fetch_instr,
    input  logic [WFID_WIDTH-1:0] fetch_wfid,
    input  logic                  flush,
    output logic [63:0]           collated_instr,
    output logic                  collate_done,
    input  logic                  collate_required,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [WFID_WIDTH-1:0] dec_wfid,
    output logic                  dec_is64,
    output logic                  collate_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        WAIT2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state;
    logic [31:0]           lo;
    logic [31:0]           hi;
    logic [WFID_WIDTH-1:0] wfid;
    logic                  is64;
    logic                  valid_q;
    logic                  done_q;
    logic                  accept;
    logic                  wfid_bad;

    // Handshake is a function of state only, except HOLD which frees up as it issues.
    assign fetch_ready = (state == IDLE) || (state == WAIT2) ||
                         ((state == HOLD) && dec_ready);
    assign accept      = fetch_valid && fetch_ready && !flush;

`ifdef DECODE_COLLATE_WFID_CHECK_EN
    assign wfid_bad = (fetch_wfid != wfid);
`else
    assign wfid_bad = 1'b0;
`endif

    assign collated_instr = {hi, lo};
    assign collate_done   = done_q;
    assign dec_valid      = valid_q;
    assign dec_wfid       = wfid;
    assign dec_is64       = is64;

    // Collation FSM with its datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lo      <= '0;
            hi      <= '0;
            wfid    <= '0;
            is64    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            lo      <= '0;
            hi      <= '0;
            is64    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lo    <= fetch_instr;
                        hi    <= '0;
                        wfid  <= fetch_wfid;
                        is64  <= 1'b0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    // An unknown collate_required is treated as a complete 32-bit word.
                    if (collate_required === 1'b1) begin
                        state <= WAIT2;
                    end else begin
                        is64    <= 1'b0;
                        valid_q <= 1'b1;
                        done_q  <= 1'b0;
                        state   <= HOLD;
                    end
                end
                WAIT2: begin
                    if (accept) begin
                        if (wfid_bad) begin
                            lo    <= fetch_instr;
                            hi    <= '0;
                            wfid  <= fetch_wfid;
                            is64  <= 1'b0;
                            state <= EVAL;
                        end else begin
                            hi      <= fetch_instr;
                            is64    <= 1'b1;
                            valid_q <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                        if (accept) begin
                            lo    <= fetch_instr;
                            hi    <= '0;
                            wfid  <= fetch_wfid;
                            is64  <= 1'b0;
                            state <= EVAL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DECODE_COLLATE_WFID_CHECK_EN
    logic err_q;

    // Single-cycle fault pulse when a second word belongs to another wavefront.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == WAIT2) && accept && wfid_bad;
        end
    end

    assign collate_err = err_q;
`else
    assign collate_err = 1'b0;
`endif

endmodule

// File: tb/tb_decode_collate_ctrl.sv
// Self-checking bench for decode_collate_ctrl: directed scenarios plus a randomized
// stream checked against a transaction-level expected-issue queue.
module tb_decode_collate_ctrl;

    localparam int unsigned W  = 6;
    localparam int unsigned NI = 60;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [31:0]   fetch_instr;
    logic [W-1:0]  fetch_wfid;
    logic          flush;
    logic [63:0]   collated_instr;
    logic          collate_done;
    logic          collate_required;
    logic          dec_valid;
    logic          dec_ready;
    logic [W-1:0]  dec_wfid;
    logic          dec_is64;
    logic          collate_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [74:0] obs;
    assign obs = {fetch_ready, dec_valid, collate_done, dec_is64, collate_err, dec_wfid, collated_instr};

    typedef struct { logic [31:0] lo; logic [31:0] hi; logic [W-1:0] wfid; logic is64; } ins_t;
    typedef struct { logic [63:0] instr; logic [W-1:0] wfid; logic is64; int cyc; } exp_t;

    decode_collate_ctrl #(.WFID_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instr(fetch_instr), .fetch_wfid(fetch_wfid),
        .flush(flush),
        .collated_instr(collated_instr), .collate_done(collate_done),
        .collate_required(collate_required),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_wfid(dec_wfid), .dec_is64(dec_is64),
        .collate_err(collate_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        logic [74:0] e;
        rst = 1'b0; fetch_valid = 1'b1; fetch_instr = 32'hDEADBEEF; fetch_wfid = 6'd9;
        flush = 1'b0; dec_ready = 1'b0; collate_required = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL reset_out: got %h want %h", obs, e); end
        @(posedge clk); #1; rst = 1'b1; fetch_valid = 1'b0; collate_required = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", obs, e); end
    endtask

    task automatic test_sopp;
        logic [74:0] e;
        @(posedge clk); #1;
        fetch_valid = 1'b1; fetch_instr = 32'hBF810000; fetch_wfid = 6'd3; dec_ready = 1'b1; collate_required = 1'b0;
        @(negedge clk);
        n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL sopp_ready: got %b want 1", fetch_ready); end
        @(posedge clk); #1; fetch_valid = 1'b0;
        @(negedge clk);
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 32'd0, 32'hBF810000};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL sopp_eval: got %h want %h", obs, e); end
        @(posedge clk); #1;
        @(negedge clk);
        e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 32'd0, 32'hBF810000};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL sopp_hold: got %h want %h", obs, e); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL sopp_idle: got %b want 0", dec_valid); end
    endtask

    task automatic test_vop3;
        logic [74:0] e;
        @(posedge clk); #1;
        fetch_valid = 1'b1; fetch_instr = 32'hD2100001; fetch_wfid = 6'd1; dec_ready = 1'b1; collate_required = 1'b0;
        @(posedge clk); #1; fetch_instr = 32'h00020501; collate_required = 1'b1;
        @(negedge clk);
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 32'd0, 32'hD2100001};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL vop3_eval: got %h want %h", obs, e); end
        @(posedge clk); #1; collate_required = 1'b0;
        @(negedge clk);
        e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 32'd0, 32'hD2100001};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL vop3_wait2: got %h want %h", obs, e); end
        @(posedge clk); #1; fetch_valid = 1'b0;
        @(negedge clk);
        e = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1, 64'h00020501_D2100001};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL vop3_hold: got %h want %h", obs, e); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL vop3_idle: got %b want 0", dec_valid); end
    endtask

    task automatic test_back_to_back;
        logic [74:0] e;
        @(posedge clk); #1;
        fetch_valid = 1'b1; fetch_instr = 32'h11111111; fetch_wfid = 6'd7; dec_ready = 1'b0; collate_required = 1'b0;
        @(posedge clk); #1; fetch_instr = 32'h22222222; fetch_wfid = 6'd9;
        @(posedge clk); #1;
        e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd7, 32'd0, 32'h11111111};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (obs !== e) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, e); end
            @(posedge clk); #1;
        end
        dec_ready = 1'b1;
        @(negedge clk);
        e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd7, 32'd0, 32'h11111111};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL b2b_handshake: got %h want %h", obs, e); end
        @(posedge clk); #1; fetch_valid = 1'b0;
        @(negedge clk);
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9, 32'd0, 32'h22222222};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL b2b_eval: got %h want %h", obs, e); end
        @(posedge clk); #1;
        @(negedge clk);
        e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 32'd0, 32'h22222222};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", obs, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_reset;
        logic [74:0] e;
        logic [67:0] f;
        @(posedge clk); #1;
        fetch_valid = 1'b1; fetch_instr = 32'hD2100001; fetch_wfid = 6'd4; dec_ready = 1'b1; collate_required = 1'b0;
        @(posedge clk); #1; collate_required = 1'b1; fetch_valid = 1'b0;
        @(posedge clk); #1; collate_required = 1'b0; fetch_valid = 1'b1; fetch_instr = 32'h00020501; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0; fetch_valid = 1'b0;
        @(negedge clk);
        f = {1'b1, 1'b0, 1'b0, 1'b0, 64'd0};
        n_tests++;
        if ({fetch_ready, dec_valid, collate_done, dec_is64, collated_instr} !== f) begin
            n_fail++; $display("FAIL flush_idle: got %h want %h",
                               {fetch_ready, dec_valid, collate_done, dec_is64, collated_instr}, f);
        end
        @(posedge clk); #1; fetch_valid = 1'b1; fetch_instr = 32'h33333333; fetch_wfid = 6'd5;
        @(posedge clk); #1; fetch_valid = 1'b0;
        @(negedge clk);
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 32'd0, 32'h33333333};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL flush_then_eval: got %h want %h", obs, e); end
        @(posedge clk); #1; dec_ready = 1'b0;
        @(negedge clk);
        e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 32'd0, 32'h33333333};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL flush_then_hold: got %h want %h", obs, e); end
        #2; rst = 1'b0; #1;
        e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL reset_in_hold: got %h want %h", obs, e); end
        @(posedge clk); #1; rst = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release[%0d]: got %b want 0", i, dec_valid); end
        end
    endtask

    task automatic test_wfid;
        logic [74:0] e;
        @(posedge clk); #1;
        fetch_valid = 1'b1; fetch_instr = 32'hD2100001; fetch_wfid = 6'd2; dec_ready = 1'b1; collate_required = 1'b0;
        @(posedge clk); #1; collate_required = 1'b1; fetch_instr = 32'h00020501; fetch_wfid = 6'd5;
        @(posedge clk); #1; collate_required = 1'b0;
        @(posedge clk); #1; fetch_valid = 1'b0;
`ifdef DECODE_COLLATE_WFID_CHECK_EN
        @(negedge clk);
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 32'd0, 32'h00020501};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL wfid_err: got %h want %h", obs, e); end
        @(posedge clk); #1;
        @(negedge clk);
        e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 32'd0, 32'h00020501};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL wfid_fresh_hold: got %h want %h", obs, e); end
`else
        @(negedge clk);
        e = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2, 64'h00020501_D2100001};
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL wfid_64: got %h want %h", obs, e); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        ins_t prog[$];
        exp_t expq[$];
        ins_t t;
        exp_t x;
        int   k = 0;
        int   cyc = 0;
        int   issued = 0;
        bit   phase_hi = 0;
        bit   eval_is64 = 0;
        bit   seen = 0;
        for (int i = 0; i < NI; i++) begin
            t.lo = $urandom; t.hi = $urandom; t.wfid = W'($urandom); t.is64 = 1'($urandom);
            prog.push_back(t);
        end
        @(posedge clk); #1;
        while (issued < NI && cyc < 4000) begin
            dec_ready = ($urandom_range(3) != 0);
            if (k < NI && $urandom_range(3) != 0) begin
                fetch_valid = 1'b1;
                fetch_instr = phase_hi ? prog[k].hi : prog[k].lo;
                fetch_wfid  = prog[k].wfid;
            end else begin
                fetch_valid = 1'b0;
                fetch_instr = $urandom;
                fetch_wfid  = W'($urandom);
            end
            #1;
            // Only the evaluate phase (neither ready nor valid) sees a meaningful collate_required.
            if (!dec_valid && !fetch_ready) collate_required = eval_is64;
            else                            collate_required = 1'($urandom);
            n_tests++; if (collate_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %b want 0", cyc, collate_err); end
            if (dec_valid) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious cyc %0d: dec_valid 1 with nothing pending", cyc);
                end else begin
                    if ({collate_done, dec_is64, dec_wfid, collated_instr} !==
                        {expq[0].is64, expq[0].is64, expq[0].wfid, expq[0].instr}) begin
                        n_fail++; $display("FAIL rnd_issue cyc %0d: got done %b is64 %b wfid %0d instr %h want done %b is64 %b wfid %0d instr %h",
                                           cyc, collate_done, dec_is64, dec_wfid, collated_instr,
                                           expq[0].is64, expq[0].is64, expq[0].wfid, expq[0].instr);
                    end
                    if (!seen) begin
                        n_tests++;
                        if (cyc != expq[0].cyc) begin
                            n_fail++; $display("FAIL rnd_latency: issued at cycle %0d want %0d", cyc, expq[0].cyc);
                        end
                        seen = 1;
                    end
                    if (dec_ready) begin
                        void'(expq.pop_front());
                        issued++;
                        seen = 0;
                    end
                end
            end
            if (fetch_valid && fetch_ready) begin
                if (!phase_hi) begin
                    eval_is64 = prog[k].is64;
                    if (prog[k].is64) begin
                        phase_hi = 1;
                    end else begin
                        x.instr = {32'd0, prog[k].lo}; x.wfid = prog[k].wfid; x.is64 = 1'b0; x.cyc = cyc + 2;
                        expq.push_back(x);
                        k++;
                    end
                end else begin
                    x.instr = {prog[k].hi, prog[k].lo}; x.wfid = prog[k].wfid; x.is64 = 1'b1; x.cyc = cyc + 1;
                    expq.push_back(x);
                    phase_hi = 0;
                    k++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        fetch_valid = 1'b0; dec_ready = 1'b1; collate_required = 1'b0;
        n_tests++;
        if (issued != NI) begin n_fail++; $display("FAIL rnd_timeout: issued %0d want %0d", issued, NI); end
    endtask

    initial begin
        test_reset();
        test_sopp();
        test_vop3();
        test_back_to_back();
        test_flush_reset();
        test_wfid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_collate_ctrl.md
DECODE_COLLATE_CTRL -- requirements
Module: decode_collate_ctrl

Interface
REQ-001 Parameter WFID_WIDTH, default 6, is the wavefront identifier width.
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low. Ports `clk` and `rst` carry them.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 fetch_valid  in  1  fetch presents an instruction word.
REQ-006 fetch_ready  out  1  controller accepts the word this cycle.
REQ-007 fetch_instr  in  32  instruction word.
REQ-008 fetch_wfid  in  WFID_WIDTH  owning wavefront.
REQ-009 flush  in  1  discard all held state.
REQ-010 collated_instr  out  64  to decode core, {hi word, lo word}.
REQ-011 collate_done  out  1  to decode core; both words are valid.
REQ-012 collate_required  in  1  from decode core; the lo word needs a second word.
REQ-013 dec_valid  out  1  decoded instruction is available downstream.
REQ-014 dec_ready  in  1  downstream consumes it.
REQ-015 dec_wfid  out  WFID_WIDTH  wavefront of the issued instruction.
REQ-016 dec_is64  out  1  issued instruction is 64-bit.
REQ-017 collate_err  out  1  one-cycle pulse on a collation fault.

Function
REQ-018 The FSM SHALL have four states: IDLE, EVAL, WAIT2, HOLD.
REQ-019 fetch_ready SHALL be 1 in IDLE and WAIT2, 1 in HOLD only when dec_ready=1, and 0 in EVAL.
REQ-020 A word is accepted when fetch_valid & fetch_ready.
- In IDLE, or in HOLD with dec_ready: lo<=fetch_instr, hi<=0, wfid<=fetch_wfid, next state EVAL.
REQ-021 In EVAL the block SHALL drive collated_instr={32'b0,lo} with collate_done=0.
- collate_required===1 -> WAIT2.
- Otherwise (0 or X) -> HOLD with dec_is64=0.
REQ-022 In WAIT2, an accepted word SHALL set hi<=fetch_instr and dec_is64<=1, next state HOLD.
REQ-023 In HOLD the block SHALL drive collated_instr={hi,lo}, with collate_done=dec_is64, and dec_valid=1.
- collated_instr, collate_done, dec_wfid and dec_is64 SHALL stay stable until dec_ready=1.
REQ-024 HOLD with dec_ready=1 and no accepted word -> IDLE. HOLD with dec_ready=1 and an accepted word -> EVAL (back-to-back).
REQ-025 Latency:
- 32-bit word accepted in cycle N -> dec_valid in cycle N+2.
- Second word accepted in cycle M -> dec_valid in cycle M+1.
REQ-026 dec_valid SHALL be 0 in IDLE, EVAL and WAIT2.
REQ-027 flush SHALL take priority over every other event.
- Next state IDLE; hi, lo, dec_is64 cleared; no word accepted in the flush cycle; dec_valid=0 the next cycle.
REQ-028 The decode core's collate_required SHALL be sampled only in EVAL and ignored elsewhere.

Reset
REQ-029 While rst=0 the block SHALL hold, independent of clk:
- state IDLE; lo, hi, wfid, dec_is64 = 0;
- collated_instr=0, collate_done=0, dec_valid=0, dec_wfid=0, dec_is64=0, collate_err=0;
- fetch_ready=1.
REQ-030 Reset asserted mid-instruction SHALL discard the held words, with no dec_valid after release.

Configuration
REQ-031 Macro DECODE_COLLATE_WFID_CHECK_EN.
- Defined: a word accepted in WAIT2 whose fetch_wfid differs from the held wfid SHALL pulse collate_err for one cycle and discard the held lo word. The new word is treated as a fresh first word (lo<=word, wfid<=fetch_wfid, state EVAL).
- Undefined: the second word SHALL be accepted regardless of fetch_wfid, and collate_err SHALL be tied to 0.

Verification
REQ-032 SOPP word 0xBF810000, wfid 3, dec_ready=1 -> EVAL presents {0,0xBF810000}, collate_done=0; dec_valid=1 two cycles after accept, dec_wfid=3, dec_is64=0.
REQ-033 VOP3a word 0xD2100001, then second word 0x00020501 -> collate_required=1 in EVAL, then WAIT2; HOLD drives 0x00020501_D2100001, collate_done=1, dec_is64=1.
REQ-034 HOLD with dec_ready=0 for 5 cycles -> outputs stable, fetch_ready=0; dec_ready=1 with a new word -> back-to-back issue, next state EVAL.
REQ-035 flush asserted in WAIT2 together with fetch_valid -> word not accepted, IDLE next, dec_valid stays 0; rst=0 in HOLD -> immediate dec_valid=0.
REQ-036 With DECODE_COLLATE_WFID_CHECK_EN: first word wfid 2, second word wfid 5 -> collate_err pulse, EVAL with wfid 5; without the macro -> 64-bit issue with dec_wfid=2.
